nibble_add_sequencer: RTL and testbench

//   Shares one 4-bit ripple-carry adder between two requesters and sequences WIDTH-bit additions through it.

---
 rtl/nibble_add_pkg.sv | 13 +
 rtl/ripple_carry_addr_4bit.sv | 25 ++
 rtl/nibble_add_sequencer.sv | 126 ++++++++++++
 tb/tb_nibble_add_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Nibble width and FSM state encodings used by the top and the adder datapath.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_addr_4bit.sv
// Gate-level 4-bit ripple-carry adder; purely combinational, no flow control.
module ripple_carry_addr_4bit
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_cout
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    logic w_p;
    assign w_p        = i_a[i] ^ i_b[i];
    assign o_sum[i]   = w_p ^ w_c[i];
    assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_p & w_c[i]);
  end

  assign o_cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Round-robin shares one 4-bit adder between two requesters, one nibble per clock, LSB first.
// Result appears NIBBLES edges after accept and is held in DONE until the consumer takes it.
module nibble_add_sequencer
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_res_valid;
  logic             r_res_cout;
  logic             r_res_id;
  logic             r_busy;

  logic             w_in_idle;
  logic             w_grant;
  logic             w_accept;
  logic [NIB_W-1:0] w_nib_a;
  logic [NIB_W-1:0] w_nib_b;
  logic [NIB_W-1:0] w_nib_sum;
  logic             w_nib_cout;

  // Requester 1 wins only when alone or when requester 0 had the previous grant.
  assign w_in_idle  = (r_state == ST_IDLE) && !rst;
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign req0_ready = w_in_idle && req0_valid && !w_grant;
  assign req1_ready = w_in_idle && req1_valid &&  w_grant;
  assign w_accept   = req0_ready || req1_ready;

  assign w_nib_a = r_a[NIB_W*r_cnt +: NIB_W];
  assign w_nib_b = r_b[NIB_W*r_cnt +: NIB_W];

  ripple_carry_addr_4bit u_adder (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_res_valid  <= 1'b0;
      r_res_cout   <= 1'b0;
      r_res_id     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // The operation's carry-in rides in the carry register for nibble 0.
            r_a          <= w_grant ? req1_a   : req0_a;
            r_b          <= w_grant ? req1_b   : req0_b;
            r_carry      <= w_grant ? req1_cin : req0_cin;
            r_res_id     <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[NIB_W*r_cnt +: NIB_W] <= w_nib_sum;
          r_carry <= w_nib_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_res_cout  <= w_nib_cout;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_sum;
  assign res_cout  = r_res_cout;
  assign res_id    = r_res_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed and randomized checks of the nibble-serial adder sequencer against an arithmetic model.
module tb_nibble_add_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_id, busy;
  logic [W-1:0] res_sum;

  int   n_checks = 0;
  int   n_err    = 0;
  logic m_last;

  nibble_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 32'({res_valid, res_cout, res_id, busy, req0_ready, req1_ready}), 0);
    chk({tag, "_sum"}, 32'(res_sum), 0);
  endtask

  // One complete operation: offer, accept, wait for result, optional stall, drain.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                        input int stall);
    logic        g;
    logic [W:0]  full;
    int          lat;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #1;
    g    = (v0 && v1) ? !m_last : v1;
    full = g ? ({1'b0, a1} + {1'b0, b1} + (W+1)'(c1))
             : ({1'b0, a0} + {1'b0, b0} + (W+1)'(c0));
    chk("ready0_offer", 32'(req0_ready), 32'(v0 && !g));
    chk("ready1_offer", 32'(req1_ready), 32'(v1 && g));
    @(posedge clk); #1;
    m_last = g;
    chk("busy_run", 32'(busy), 1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      chk("ready_run", 32'({req0_ready, req1_ready}), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, W / 4);
    chk("sum", 32'(res_sum), 32'(full[W-1:0]));
    chk("cout", 32'(res_cout), 32'(full[W]));
    chk("id", 32'(res_id), 32'(g));
    for (int s = 0; s < stall; s++) begin
      res_ready = 1'b0;
      chk("ready_done", 32'({req0_ready, req1_ready}), 0);
      @(posedge clk); #1;
      chk("stall_hold", 32'({res_valid, busy, res_cout, res_id}), 32'({2'b11, full[W], g}));
      chk("stall_sum", 32'(res_sum), 32'(full[W-1:0]));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("drain", 32'({res_valid, busy}), 0);
  endtask

  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic [1:0]   vm;

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    m_last = 1'b1;
    #3;
    chk_all_zero("reset");
    req0_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Both valid from reset: req0 first, then req1.
    run_op(1'b1, 1'b1, 16'd1, 16'd2, 1'b0, 16'd3, 16'd4, 1'b0, 0);
    run_op(1'b1, 1'b1, 16'd1, 16'd2, 1'b0, 16'd3, 16'd4, 1'b0, 0);

    run_op(1'b1, 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    run_op(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 0);

    // Held contention alternates grants.
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, W'($urandom), W'($urandom), 1'b1, 0);

    run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0, 16'h0, 1'b0, 3);

    // Valid withdrawn before the edge: nothing starts.
    req0_valid = 1'b0; req1_valid = 1'b1;
    #1;
    chk("offer_only", 32'(req1_ready), 1);
    req1_valid = 1'b0;
    #1;
    chk("withdrawn_ready", 32'(req1_ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("withdrawn_idle", 32'({busy, res_valid}), 0);

    for (int i = 0; i < 24; i++) begin
      vm  = 2'($urandom_range(1, 3));
      ra0 = W'($urandom); rb0 = W'($urandom);
      ra1 = W'($urandom); rb1 = W'($urandom);
      run_op(vm[0], vm[1], ra0, rb0, 1'($urandom), ra1, rb1, 1'($urandom), $urandom_range(0, 2));
    end

    // Abort mid-RUN after a req0 grant; round robin must restart at req0.
    req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    req0_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    m_last = 1'b1;
    run_op(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0, 16'h1111, 16'h0001, 1'b0, 0);
    chk("post_abort_sum", 32'(res_sum), 32'h5555);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
